// File: rtl/ppr_topk_select.sv
// Scans node scores 1..NODE_NUM from BRAM, keeps a sorted TOP_K list, streams it highest first.
// Latency: NODE_NUM+2 cycles from accepted i_start to first o_valid; one entry per cycle after that.
// Backpressure: o_valid holds with stable o_node/o_score/o_last until i_ready; the scan itself never stalls.
module ppr_topk_select #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 32,
  parameter int SCORE_TABLE_OFFSET = 1000,
  parameter int NODE_NUM           = 100,
  parameter int TOP_K              = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic                  o_bram_rd_en,
  input  logic [DATA_WIDTH-1:0] i_bram_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_node,
  output logic [DATA_WIDTH-1:0] o_score,
  output logic                  o_last
);

  localparam int NW = $clog2(NODE_NUM + 1);
  localparam int EW = (TOP_K > 1) ? $clog2(TOP_K) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLUSH, S_EMIT, S_DONE} state_e;

  state_e state_q, state_d;

  logic [NW-1:0] rd_node_q;   // next node whose score slot is read
  logic          rd_vld_q;    // i_bram_rdata holds a score this cycle
  logic [NW-1:0] rd_id_q;     // node the returned score belongs to
  logic [EW-1:0] emit_q;      // list position currently presented

  logic [DATA_WIDTH-1:0] node_q  [TOP_K];
  logic [DATA_WIDTH-1:0] score_q [TOP_K];
  logic [TOP_K-1:0]      vld_q;

  logic [DATA_WIDTH-1:0] node_d  [TOP_K];
  logic [DATA_WIDTH-1:0] score_d [TOP_K];
  logic [TOP_K-1:0]      vld_d;

  logic [DATA_WIDTH-1:0] node_sh  [TOP_K];
  logic [DATA_WIDTH-1:0] score_sh [TOP_K];
  logic [TOP_K-1:0]      vld_sh;
  logic [TOP_K-1:0]      gt;
  logic [TOP_K-1:0]      prev_gt;
  logic [TOP_K-1:0]      vld_nx;
  logic                  ins_en;

  logic [DATA_WIDTH-1:0] sel_node;
  logic [DATA_WIDTH-1:0] sel_score;
  logic                  sel_last;

  // Sorted insert: the list is contiguous and descending, so gt[] is a thermometer;
  // its first set bit takes the new entry and the rest take their upper neighbour.
  // Strict compare keeps an earlier node ahead of a later one with an equal score.
  always_comb begin
    ins_en = rd_vld_q && (i_bram_rdata != '0);
    for (int i = 0; i < TOP_K; i++) begin
      gt[i] = !vld_q[i] || (i_bram_rdata > score_q[i]);
    end
    prev_gt     = '0;
    node_sh[0]  = '0;
    score_sh[0] = '0;
    vld_sh[0]   = 1'b0;
    for (int i = 1; i < TOP_K; i++) begin
      prev_gt[i]  = gt[i-1];
      node_sh[i]  = node_q[i-1];
      score_sh[i] = score_q[i-1];
      vld_sh[i]   = vld_q[i-1];
    end
    node_d  = node_q;
    score_d = score_q;
    vld_d   = vld_q;
    if (ins_en) begin
      for (int i = 0; i < TOP_K; i++) begin
        if (gt[i] && !prev_gt[i]) begin
          node_d[i]  = DATA_WIDTH'(rd_id_q);
          score_d[i] = i_bram_rdata;
          vld_d[i]   = 1'b1;
        end else if (gt[i]) begin
          node_d[i]  = node_sh[i];
          score_d[i] = score_sh[i];
          vld_d[i]   = vld_sh[i];
        end
      end
    end
  end

  // Select the entry at the emit index and flag it last when its successor is empty.
  always_comb begin
    vld_nx = '0;
    for (int i = 0; i < TOP_K - 1; i++) begin
      vld_nx[i] = vld_q[i+1];
    end
    sel_node  = '0;
    sel_score = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < TOP_K; i++) begin
      if (emit_q == EW'(i)) begin
        sel_node  = node_q[i];
        sel_score = score_q[i];
        sel_last  = !vld_nx[i];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all block outputs; outputs are zero outside the states that drive them.
  always_comb begin
    state_d      = state_q;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_bram_addr  = '0;
    o_bram_rd_en = 1'b0;
    o_valid      = 1'b0;
    o_node       = '0;
    o_score      = '0;
    o_last       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_SCAN;
      end
      S_SCAN: begin
        o_busy       = 1'b1;
        o_bram_rd_en = 1'b1;
        o_bram_addr  = ADDR_WIDTH'(SCORE_TABLE_OFFSET) + ADDR_WIDTH'(rd_node_q);
        if (rd_node_q == NW'(NODE_NUM)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // The final score is inserted on this edge, so look at the updated list.
        o_busy  = 1'b1;
        state_d = vld_d[0] ? S_EMIT : S_DONE;
      end
      S_EMIT: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_node  = sel_node;
        o_score = sel_score;
        o_last  = sel_last;
        if (i_ready && sel_last) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read address counter, returned-word tag and emit index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_node_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_id_q   <= '0;
      emit_q    <= '0;
    end else begin
      rd_vld_q <= (state_q == S_SCAN);
      rd_id_q  <= rd_node_q;
      if (state_q == S_IDLE) begin
        rd_node_q <= NW'(1);
      end else if (state_q == S_SCAN) begin
        rd_node_q <= rd_node_q + NW'(1);
      end
      if (state_q != S_EMIT) begin
        emit_q <= '0;
      end else if (i_ready) begin
        emit_q <= emit_q + EW'(1);
      end
    end
  end

  // Top-K list storage; emptied whenever the block is idle or finishing.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < TOP_K; i++) begin
        node_q[i]  <= '0;
        score_q[i] <= '0;
      end
    end else if (state_q == S_IDLE || state_q == S_DONE) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < TOP_K; i++) begin
        node_q[i]  <= node_d[i];
        score_q[i] <= score_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ppr_topk_select.sv
// Directed scenarios for ppr_topk_select with a queue scoreboard and a negedge monitor.
// Each run checks emitted entries, first-valid and done timing against hand-computed values.
// Covers ready backpressure, ignored restart, mid-scan reset and the BRAM address sequence.
module tb_ppr_topk_select;

  localparam int N   = 10;
  localparam int K   = 4;
  localparam int OFF = 1000;
  localparam int AW  = 13;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          busy, done, rd_en, valid, last;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] node, score;

  ppr_topk_select #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCORE_TABLE_OFFSET(OFF), .NODE_NUM(N), .TOP_K(K)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_bram_addr(addr), .o_bram_rd_en(rd_en), .i_bram_rdata(rdata),
    .o_valid(valid), .i_ready(ready), .o_node(node), .o_score(score), .o_last(last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rdata <= mem[addr];

  typedef struct { logic [DW-1:0] node; logic [DW-1:0] score; logic last; } exp_t;
  exp_t expq[$];
  int   addrq[$];
  int   relq[$];

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  int first_valid_rel = -1;
  int done_rel = -1;
  int done_cnt = 0;
  bit bp_mode = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, done timing, read address log.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_node, prev_score;
  logic          prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", valid, 1);
        chk("stall_node_held", node, prev_node);
        chk("stall_score_held", score, prev_score);
        chk("stall_last_held", last, prev_last);
      end
      if (valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (valid && ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_entry_node", node, 0);
          errors += (node == 0) ? 1 : 0;
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("entry_node", node, e.node);
          chk("entry_score", score, e.score);
          chk("entry_last", last, e.last);
        end
      end
      if (done) begin
        chk("done_valid_exclusive", valid, 0);
        done_cnt++;
        done_rel = cyc - start_cyc;
      end
      if (rd_en) begin
        addrq.push_back(int'(addr));
        relq.push_back(cyc - start_cyc);
      end
      prev_stall = valid && !ready;
      prev_node  = node;
      prev_score = score;
      prev_last  = last;
    end
  end

  // Ready driver: held high, or the 0,0,1 pattern when backpressure is enabled.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        ready = (ph == 2);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic load(input int s[N]);
    for (int n = 1; n <= N; n++) mem[OFF + n] = s[n-1];
  endtask

  task automatic push(input int n, input int s, input bit l);
    exp_t e;
    e.node = n; e.score = s; e.last = l;
    expq.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_node"}, node, 0);
    chk({tag, "_score"}, score, 0);
  endtask

  // Issue i_start (called #1 after a posedge), optionally pulse it again mid-scan,
  // then wait for o_done and check timing and that every expected entry came out.
  task automatic run_scan(input string tag, input int v, input bit check_lat, input int repulse_at);
    int d0;
    d0 = done_cnt;
    first_valid_rel = -1;
    done_rel = -1;
    addrq.delete();
    relq.delete();
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (repulse_at > 0) begin
      while (cyc - start_cyc < repulse_at - 1) begin
        @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    if (check_lat) chk({tag, "_done_cycle"}, done_rel, N + 2 + v);
    if (v > 0) chk({tag, "_first_valid_cycle"}, first_valid_rel, N + 2);
    else       chk({tag, "_no_valid"}, first_valid_rel, -1);
    chk({tag, "_entries_left"}, expq.size(), 0);
    #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
    expq.delete();
  endtask

  int sc1[N] = '{5, 90, 12, 0, 33, 7, 90, 1, 60, 0};
  int sc0[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int sc2[N] = '{0, 0, 4, 0, 0, 0, 0, 4, 0, 0};

  task automatic push_sc1();
    push(2, 90, 0); push(7, 90, 0); push(9, 60, 0); push(5, 33, 1);
  endtask

  initial begin
    int d0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Distinct scores, ready held high; also the read address sequence.
    load(sc1);
    push_sc1();
    run_scan("distinct", 4, 1'b1, 0);
    chk("addr_count", addrq.size(), N);
    for (int i = 0; i < addrq.size() && i < N; i++) begin
      chk($sformatf("addr_%0d", i), addrq[i], OFF + 1 + i);
      chk($sformatf("addr_cycle_%0d", i), relq[i], i + 1);
    end

    // Nothing qualifies.
    @(posedge clk); #1;
    load(sc0);
    run_scan("allzero", 0, 1'b1, 0);

    // Equal scores keep node order.
    @(posedge clk); #1;
    load(sc2);
    push(3, 4, 0); push(8, 4, 1);
    run_scan("ties", 2, 1'b1, 0);

    // Backpressure 0,0,1.
    @(posedge clk); #1;
    load(sc1);
    push_sc1();
    bp_mode = 1'b1;
    run_scan("backpressure", 4, 1'b0, 0);
    bp_mode = 1'b0;

    // Second i_start during scan is ignored.
    @(posedge clk); #1;
    push_sc1();
    run_scan("restart_ignored", 4, 1'b1, 4);

    // Reset in cycle 6 of a scan aborts it without o_done.
    @(posedge clk); #1;
    d0 = done_cnt;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc - start_cyc < 5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - d0, 0);
    push_sc1();
    run_scan("after_reset", 4, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ppr_topk_select.md
# ppr_topk_select

Downstream of the random-walk scoring stage. Once the score table in BRAM holds final, degree-normalised scores, this block scans every node's score entry, keeps a sorted list of the TOP_K highest-scoring nodes and streams them out, highest first, over a valid/ready interface. It is the last step of the PPR pipeline, between the shared BRAM and the host/result FIFO.

## Interface
Parameters:
- ADDR_WIDTH, 13, BRAM address width
- DATA_WIDTH, 32, BRAM word width and score width (unsigned)
- SCORE_TABLE_OFFSET, 1000, BRAM address of node 0's score slot; node n lives at SCORE_TABLE_OFFSET + n
- NODE_NUM, 100, nodes scanned are 1..NODE_NUM (no node 0)
- TOP_K, 8, list depth (1..16)

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle request to begin a scan; sampled only in IDLE
- o_busy  out  1  high from the cycle after i_start is accepted until done
- o_done  out  1  one-cycle pulse when the last entry has been emitted, or at the end of the scan if none qualify
- o_bram_addr  out  ADDR_WIDTH  read address to the shared BRAM
- o_bram_rd_en  out  1  high on cycles where o_bram_addr is a valid read
- i_bram_rdata  in  DATA_WIDTH  BRAM read data, valid one cycle after the address
- o_valid  out  1  result entry valid
- i_ready  in  1  consumer accepts the entry when o_valid && i_ready
- o_node  out  DATA_WIDTH  node ID of the current entry
- o_score  out  DATA_WIDTH  score of the current entry
- o_last  out  1  high with the final emitted entry

## Operation
- States: IDLE, SCAN, FLUSH, EMIT, DONE.
- IDLE: list cleared (all entry valid bits 0). i_start=1 -> SCAN, rd node counter = 1.
- SCAN: each cycle drive o_bram_addr = SCORE_TABLE_OFFSET + node, o_bram_rd_en=1, node += 1. After issuing node NODE_NUM -> FLUSH.
- FLUSH: one cycle, no read issued; absorbs the last returned word. -> EMIT if any entry valid, else DONE.
- Insertion: the returned word for node k is processed in the cycle it is valid. A score of 0 is skipped (node never visited). Otherwise it is inserted at the first position i where the entry is invalid or s > score[i] (unsigned, strict); entries i..K-2 shift down by one; entry K-1 is dropped. On equal scores the earlier (lower) node ID keeps precedence. Exactly one insertion per cycle, one cycle of compare+shift.
- EMIT: present entry at emit index e (starting 0): o_valid=1, o_node/o_score = entry[e], o_last = 1 when e is the last valid entry. On o_valid && i_ready: e += 1; after the o_last handshake -> DONE.
- DONE: o_done=1 for one cycle, o_busy=0, clear list -> IDLE.
- i_start outside IDLE is ignored. The BRAM is read-only from this block; it never drives a write.

## Timing
- Reset (i_rst_n=0 at a rising edge): state IDLE; o_busy, o_done, o_valid, o_last, o_bram_rd_en = 0; o_bram_addr, o_node, o_score = 0; list cleared. Reset mid-scan or mid-emit aborts with no o_done.
- i_start sampled at edge E0: reads at E1..E_NODE_NUM; node k's data valid in cycle k+1; last insert at edge E_NODE_NUM+1 (FLUSH); o_valid first high in cycle NODE_NUM+2.
- With i_ready held high, one entry per cycle; total i_start-to-o_done = NODE_NUM + 2 + V cycles (V = valid entries, ≤ TOP_K). With V=0, o_done is the cycle after FLUSH.
- i_ready low: o_valid stays high, o_node/o_score/o_last held stable (AXI-stream rule: valid never drops without a handshake).
- o_done and o_valid are never high in the same cycle.

## Test plan
Bench parameters: NODE_NUM=10, TOP_K=4, SCORE_TABLE_OFFSET=1000; BRAM model with 1-cycle read latency.
- Distinct scores nodes 1..10 = {5,90,12,0,33,7,90,1,60,0}; i_start, i_ready=1 -> emits (2,90),(7,90),(9,60),(5,33), o_last on (5,33), first o_valid 12 cycles after start, o_done next cycle.
- All scores 0 -> no o_valid ever; o_done pulse 12 cycles after start; o_busy low afterwards.
- Only nodes 3 (=4) and 8 (=4) nonzero -> emits (3,4) then (8,4) with o_last on second; V=2.
- Backpressure: first scenario with i_ready toggling 0,0,1 repeated -> same order, outputs stable while i_ready=0, no entry duplicated or lost.
- i_i_start pulsed again during SCAN is ignored; i_rst_n low at cycle 6 of SCAN -> all outputs 0 next cycle, no o_done; new i_start then gives the full first-scenario result.
- Address check: o_bram_addr sequence 1001..1010 with o_bram_rd_en high for exactly 10 consecutive cycles.
